decode_issue_ctrl: RTL and testbench

//  Sequences the ID stage. Holds one fetched instruction in a slot register and

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/reg_scoreboard.sv | 53 +++++
 rtl/decode_issue_ctrl.sv | 99 +++++++++
 tb/tb_decode_issue_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode constants and operand-class helpers shared by the ID stage
package cpu_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_IW    = 7'b0011011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  // Unknown opcodes fall to default: no sources, no destination.
  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_IW, OP_S, OP_B, OP_JALR, OP_LOAD: uses_rs1 = 1'b1;
      default:                                         uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_R, OP_S, OP_B: uses_rs2 = 1'b1;
      default:          uses_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
    case (op)
      OP_R, OP_I, OP_IW, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD:
        writes_rd = (rd != 5'd0);
      default:
        writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-writer mask and in-flight writer counter
module reg_scoreboard #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_valid,
  input  logic [4:0] set_rd,
  input  logic       clr_valid,
  input  logic [4:0] clr_rd,
  input  logic [4:0] rd_a_addr,
  output logic       rd_a_busy,
  input  logic [4:0] rd_b_addr,
  output logic       rd_b_busy,
  input  logic [4:0] dst_addr,
  output logic       dst_busy,
  output logic       full
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic [31:0]   pending_q, pending_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          dec_ok;

  assign dec_ok = clr_valid & (inflight_q != '0);

  always_comb begin
    pending_d  = pending_q;
    inflight_d = inflight_q;
    // Clear first so a same-register set in the same cycle wins.
    if (clr_valid) pending_d[clr_rd] = 1'b0;
    if (set_valid) pending_d[set_rd] = 1'b1;
    if (set_valid && !dec_ok)      inflight_d = inflight_q + IW'(1);
    else if (!set_valid && dec_ok) inflight_d = inflight_q - IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q  <= '0;
      inflight_q <= '0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
    end
  end

  assign rd_a_busy = pending_q[rd_a_addr];
  assign rd_b_busy = pending_q[rd_b_addr];
  assign dst_busy  = pending_q[dst_addr];
  assign full      = (inflight_q == IW'(MAX_INFLIGHT));

endmodule

// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - ID-stage slot, RAW/WAW hazard check and issue handshake
module decode_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [31:0]      fetch_instr,
  input  logic [31:0]      fetch_pc,
  output logic [31:0]      dec_instr,
  output logic [31:0]      dec_pc,
  input  logic [6:0]       dec_opcode,
  input  logic [4:0]       dec_rd,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [31:0]      iss_instr,
  output logic [31:0]      iss_pc,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_count
);

  slot_t            slot_q, slot_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic use1, use2, wrd;
  logic rs1_busy, rs2_busy, rd_busy, sb_full;
  logic hazard, issue;

  assign use1 = uses_rs1(dec_opcode);
  assign use2 = uses_rs2(dec_opcode);
  assign wrd  = writes_rd(dec_opcode, dec_rd);

  reg_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (issue & wrd),
    .set_rd    (dec_rd),
    .clr_valid (wb_valid),
    .clr_rd    (wb_rd),
    .rd_a_addr (dec_rs1),
    .rd_a_busy (rs1_busy),
    .rd_b_addr (dec_rs2),
    .rd_b_busy (rs2_busy),
    .dst_addr  (dec_rd),
    .dst_busy  (rd_busy),
    .full      (sb_full)
  );

  assign hazard = slot_q.valid &
                  ((use1 & (dec_rs1 != 5'd0) & rs1_busy) |
                   (use2 & (dec_rs2 != 5'd0) & rs2_busy) |
                   (wrd & (rd_busy | sb_full)));

  // Gated by rst_n so nothing can issue in a reset cycle.
  assign iss_valid   = rst_n & slot_q.valid & ~hazard & ~flush;
  assign issue       = iss_valid & iss_ready;
  assign fetch_ready = ~flush & (~slot_q.valid | issue);

  always_comb begin
    slot_d        = slot_q;
    stall_count_d = stall_count_q;
    if (flush) begin
      slot_d.valid = 1'b0;
    end else if (fetch_valid && fetch_ready) begin
      slot_d.valid = 1'b1;
      slot_d.instr = fetch_instr;
      slot_d.pc    = fetch_pc;
    end else if (issue) begin
      slot_d.valid = 1'b0;
    end
    if (slot_q.valid && !iss_valid && !flush && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q        <= '0;
      stall_count_q <= '0;
    end else begin
      slot_q        <= slot_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign dec_instr   = slot_q.instr;
  assign dec_pc      = slot_q.pc;
  assign iss_instr   = slot_q.instr;
  assign iss_pc      = slot_q.pc;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb/tb_decode_issue_ctrl.sv - directed scenarios plus random traffic against a cycle model
module tb_decode_issue_ctrl;

  logic        clk, rst_n;
  logic        fetch_valid, fetch_ready;
  logic [31:0] fetch_instr, fetch_pc, dec_instr, dec_pc, iss_instr, iss_pc;
  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2, wb_rd;
  logic        iss_valid, iss_ready, wb_valid, flush;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;

  decode_issue_ctrl #(.MAX_INFLIGHT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_instr(iss_instr), .iss_pc(iss_pc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .stall_count(stall_count)
  );

  // Stand-in for the external combinational decoder.
  assign dec_opcode = dec_instr[6:0];
  assign dec_rd     = dec_instr[11:7];
  assign dec_rs1    = dec_instr[19:15];
  assign dec_rs2    = dec_instr[24:20];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] ADDI = 7'b0010011, ADD = 7'b0110011, SUB = 7'b0110011, LUI = 7'b0110111;

  // Reference model state
  bit          m_sv;
  logic [31:0] m_instr, m_pc;
  bit          m_pend [32];
  int          m_infl, m_stall;
  bit          obs_iv, obs_fr;
  logic [31:0] pc_ctr = 32'h1000;

  function automatic bit known(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0011011, 7'b0100011, 7'b1100011,
                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011};
  endfunction
  function automatic bit m_u1(input logic [6:0] op);
    return known(op) && !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
  endfunction
  function automatic bit m_u2(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0100011, 7'b1100011};
  endfunction
  function automatic bit m_wr(input logic [6:0] op, input logic [4:0] rd);
    return known(op) && !(op inside {7'b0100011, 7'b1100011}) && rd != 0;
  endfunction
  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  task automatic step(input bit rst, input bit fv, input logic [31:0] instr, input bit ir,
                      input bit wbv, input logic [4:0] wbrd, input bit fl);
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    bit haz, e_iv, e_fr, issue, w;
    @(negedge clk);
    rst_n = rst; fetch_valid = fv; fetch_instr = instr; fetch_pc = pc_ctr;
    iss_ready = ir; wb_valid = wbv; wb_rd = wbrd; flush = fl;
    #1;
    op = m_instr[6:0]; rd = m_instr[11:7]; rs1 = m_instr[19:15]; rs2 = m_instr[24:20];
    w = m_wr(op, rd);
    haz = m_sv && ((m_u1(op) && rs1 != 0 && m_pend[rs1]) || (m_u2(op) && rs2 != 0 && m_pend[rs2])
                   || (w && (m_pend[rd] || m_infl == 4)));
    e_iv = rst && m_sv && !haz && !fl;
    e_fr = !fl && (!m_sv || (e_iv && ir));
    obs_iv = iss_valid; obs_fr = fetch_ready;
    checks++;
    if (iss_valid !== e_iv) begin
      failures++; $display("FAIL iss_valid got=%b exp=%b t=%0t", iss_valid, e_iv, $time);
    end
    if (rst) begin
      checks += 2;
      if (fetch_ready !== e_fr) begin
        failures++; $display("FAIL fetch_ready got=%b exp=%b t=%0t", fetch_ready, e_fr, $time);
      end
      if (dec_instr !== m_instr) begin
        failures++; $display("FAIL dec_instr got=%h exp=%h t=%0t", dec_instr, m_instr, $time);
      end
      if (e_iv) begin
        checks++;
        if (iss_instr !== m_instr || iss_pc !== m_pc) begin
          failures++;
          $display("FAIL iss_payload got=%h/%h exp=%h/%h", iss_instr, iss_pc, m_instr, m_pc);
        end
      end
    end
    @(posedge clk);
    if (!rst) begin
      m_sv = 0; m_instr = 0; m_pc = 0; m_infl = 0; m_stall = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      issue = e_iv && ir;
      if (wbv) begin
        if (m_infl > 0) m_infl--;
        m_pend[wbrd] = 0;
      end
      if (issue && w) begin
        m_pend[rd] = 1; m_infl++;
      end
      if (m_sv && !e_iv && !fl && m_stall < 65535) m_stall++;
      if (fl) m_sv = 0;
      else if (fv && e_fr) begin
        m_sv = 1; m_instr = instr; m_pc = pc_ctr;
      end else if (issue) m_sv = 0;
    end
    pc_ctr += 4;
    #1;
    checks++;
    if (stall_count !== 16'(m_stall)) begin
      failures++; $display("FAIL stall_count got=%0d exp=%0d t=%0t", stall_count, m_stall, $time);
    end
  endtask

  task automatic cyc(input bit fv, input logic [31:0] instr, input bit ir,
                     input bit wbv, input logic [4:0] wbrd, input bit fl);
    step(1'b1, fv, instr, ir, wbv, wbrd, fl);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (iss_valid !== 1'b0)     begin failures++; $display("FAIL reset_iss_valid got=%b exp=0", iss_valid); end
    if (fetch_ready !== 1'b1)   begin failures++; $display("FAIL reset_fetch_ready got=%b exp=1", fetch_ready); end
    if (dec_instr !== 32'd0)    begin failures++; $display("FAIL reset_dec_instr got=%h exp=0", dec_instr); end
    if (stall_count !== 16'd0)  begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1, enc(ADDI, 1, 0, 0), 1, 0, 0, 0);
    cyc(1, enc(ADDI, 2, 0, 0), 1, 0, 0, 0);
    checks++; if (obs_iv !== 1) begin failures++; $display("FAIL b2b_first got=%b exp=1", obs_iv); end
    cyc(0, 0, 1, 1, 1, 0);
    checks++; if (obs_iv !== 1) begin failures++; $display("FAIL b2b_second got=%b exp=1", obs_iv); end
    cyc(0, 0, 1, 1, 2, 0);
    checks++; if (stall_count !== 0) begin failures++; $display("FAIL b2b_stall got=%0d exp=0", stall_count); end
  endtask

  task automatic test_raw();
    do_reset();
    cyc(1, enc(ADD, 3, 1, 2), 1, 0, 0, 0);
    cyc(1, enc(SUB, 4, 3, 1), 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      checks++; if (obs_iv !== 0) begin failures++; $display("FAIL raw_hold got=%b exp=0", obs_iv); end
    end
    cyc(0, 0, 1, 1, 3, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks += 2;
    if (obs_iv !== 1) begin failures++; $display("FAIL raw_release got=%b exp=1", obs_iv); end
    if (stall_count !== 4) begin failures++; $display("FAIL raw_stall got=%0d exp=4", stall_count); end
  endtask

  task automatic test_no_source();
    do_reset();
    cyc(1, enc(ADDI, 1, 0, 0), 1, 0, 0, 0);
    cyc(1, enc(ADDI, 2, 0, 0), 1, 0, 0, 0);
    cyc(1, enc(ADDI, 3, 0, 0), 1, 0, 0, 0);
    cyc(1, enc(LUI, 5, 1, 2), 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (obs_iv !== 1) begin failures++; $display("FAIL lui_issue got=%b exp=1", obs_iv); end
  endtask

  task automatic test_inflight_limit();
    do_reset();
    for (int r = 1; r <= 5; r++) cyc(1, enc(ADDI, 5'(r), 0, 0), 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (obs_iv !== 0) begin failures++; $display("FAIL limit_hold got=%b exp=0", obs_iv); end
    cyc(0, 0, 1, 1, 1, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (obs_iv !== 1) begin failures++; $display("FAIL limit_release got=%b exp=1", obs_iv); end
  endtask

  task automatic test_flush();
    do_reset();
    cyc(1, enc(ADDI, 1, 0, 0), 1, 0, 0, 0);
    cyc(1, enc(ADD, 2, 1, 0), 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, enc(ADD, 2, 1, 0), 1, 0, 0, 1);
    checks++; if (obs_fr !== 0) begin failures++; $display("FAIL flush_fetch_ready got=%b exp=0", obs_fr); end
    cyc(1, enc(ADD, 2, 1, 0), 1, 0, 0, 0);
    checks++; if (obs_fr !== 1) begin failures++; $display("FAIL flush_refill got=%b exp=1", obs_fr); end
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (obs_iv !== 0) begin failures++; $display("FAIL flush_pending_kept got=%b exp=0", obs_iv); end
  endtask

  task automatic test_same_cycle_and_reset();
    do_reset();
    cyc(1, enc(ADDI, 1, 0, 0), 1, 0, 0, 0);
    cyc(1, enc(ADDI, 7, 0, 0), 1, 0, 0, 0);
    cyc(1, enc(ADD, 8, 7, 0), 1, 1, 7, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (obs_iv !== 0) begin failures++; $display("FAIL setwins_hold got=%b exp=0", obs_iv); end
    cyc(0, 0, 1, 0, 0, 0);
    do_reset();
    checks += 3;
    if (stall_count !== 0) begin failures++; $display("FAIL midreset_stall got=%0d exp=0", stall_count); end
    if (dec_instr !== 0)   begin failures++; $display("FAIL midreset_dec got=%h exp=0", dec_instr); end
    if (iss_valid !== 0)   begin failures++; $display("FAIL midreset_iv got=%b exp=0", iss_valid); end
    cyc(1, enc(ADD, 8, 7, 0), 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    checks++; if (obs_iv !== 1) begin failures++; $display("FAIL midreset_sb_clear got=%b exp=1", obs_iv); end
  endtask

  task automatic test_random();
    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0011011, 7'b0100011, 7'b1100011,
                             7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b1111111};
    int plist [$];
    logic [31:0] ins;
    logic [4:0] wr;
    bit wv;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 10)];
      ins[11:7] = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      plist.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) plist.push_back(r);
      wv = 0; wr = 5'($urandom_range(0, 31));
      if (plist.size() > 0 && $urandom_range(0, 2) == 0) begin
        wv = 1; wr = 5'(plist[$urandom_range(0, plist.size() - 1)]);
      end
      step($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0, ins,
           $urandom_range(0, 3) != 0, wv, wr, $urandom_range(0, 19) == 0);
    end
  endtask

  initial begin
    rst_n = 0; fetch_valid = 0; fetch_instr = 0; fetch_pc = 0;
    iss_ready = 0; wb_valid = 0; wb_rd = 0; flush = 0;
    m_sv = 0; m_instr = 0; m_pc = 0; m_infl = 0; m_stall = 0;
    test_reset();
    test_back_to_back();
    test_raw();
    test_no_source();
    test_inflight_limit();
    test_flush();
    test_same_cycle_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
